// File: rtl/dram_pkg.sv
// Shared parameters and FSM encodings for the DRAM bank model that sits
// downstream of the Freddie strobe generator.
package dram_pkg;

    localparam int ROW_W_DEF  = 8;
    localparam int COL_W_DEF  = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int BA_W       = 8;
    localparam int ADDR_W     = ROW_W_DEF + COL_W_DEF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROW_ACT   = 3'd1,
        COL_ACT   = 3'd2,
        CAS_FIRST = 3'd3,
        CBR       = 3'd4,
        WAIT_HI   = 3'd5
    } state_t;

endpackage

// File: rtl/dram_array_model_mem.sv
// Bank storage: synchronous write, registered read, contents survive reset.
module dram_mem
    import dram_pkg::*;
#(
    parameter int MEM_ADDR_W = ADDR_W,
    parameter int MEM_DATA_W = DATA_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  we,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [0:(1 << MEM_ADDR_W)-1];

    // Read returns the pre-write contents when read and write share a cycle.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dram_array_model.sv
// Cycle-sampled DRAM bank: rebuilds {row,col} from the multiplexed strobes,
// serves reads/writes/page mode, counts refreshes and flags strobe misuse.
module dram_array_model
    import dram_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int COL_W  = COL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              ras,
    input  logic              cas,
    input  logic              w,
    input  logic [BA_W-1:0]   ba,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  refresh_count,
    output logic              err_proto
);

    localparam int AW = ROW_W + COL_W;

    state_t             state;
    logic               ras_q;
    logic               cas_q;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               written;
    logic               cas_seen;

    logic               ras_fall;
    logic               ras_rise;
    logic               cas_fall;
    logic               cas_rise;
    logic               cas_entry;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DATA_W-1:0]  mem_rdata;

    assign ras_fall = ras_q & ~ras;
    assign ras_rise = ~ras_q & ras;
    assign cas_fall = cas_q & ~cas;
    assign cas_rise = ~cas_q & cas;

    assign cas_entry = (state == ROW_ACT) && cas_fall && !ras_rise;

    // On the CAS-fall sample the column is still on ba, not yet in col.
    always_comb begin
        mem_addr = {row, col};
        mem_we   = 1'b0;
        if (cas_entry) begin
            mem_addr = {row, ba[COL_W-1:0]};
        end
        if (!rst) begin
            if (cas_entry && !w) begin
                mem_we = 1'b1;
            end else if (state == COL_ACT && !written && !cas && !w) begin
                mem_we = 1'b1;
            end
        end
    end

    dram_mem #(
        .MEM_ADDR_W (AW),
        .MEM_DATA_W (DATA_W)
    ) u_mem (
        .clk_in (clk_in),
        .we     (mem_we),
        .addr   (mem_addr),
        .wdata  (din),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            ras_q         <= 1'b1;
            cas_q         <= 1'b1;
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            written       <= 1'b0;
            cas_seen      <= 1'b0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            access_count  <= '0;
            refresh_count <= '0;
            err_proto     <= 1'b0;
        end else begin
            ras_q     <= ras;
            cas_q     <= cas;
            err_proto <= 1'b0;
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (ras_fall && cas_fall) begin
                        err_proto <= 1'b1;
                        state     <= WAIT_HI;
                    end else if (ras_fall && cas) begin
                        row      <= ba[ROW_W-1:0];
                        cas_seen <= 1'b0;
                        state    <= ROW_ACT;
                    end else if (cas_fall && ras) begin
                        state <= CAS_FIRST;
                    end
                end
                ROW_ACT: begin
                    dout_valid <= 1'b0;
                    if (ras_rise && cas_fall) begin
                        err_proto <= 1'b1;
                        state     <= WAIT_HI;
                    end else if (cas_fall) begin
                        col      <= ba[COL_W-1:0];
                        written  <= ~w;
                        cas_seen <= 1'b1;
                        state    <= COL_ACT;
                    end else if (ras_rise) begin
                        // Only a row opened and closed without any CAS is a refresh.
                        if (!cas_seen) begin
                            refresh_count <= refresh_count + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                COL_ACT: begin
                    if (ras_rise) begin
                        access_count <= access_count + CNT_W'(1);
                        dout_valid   <= 1'b0;
                        state        <= WAIT_HI;
                    end else if (cas_rise) begin
                        access_count <= access_count + CNT_W'(1);
                        dout_valid   <= 1'b0;
                        state        <= ROW_ACT;
                    end else begin
                        dout       <= mem_rdata;
                        dout_valid <= ~(written | mem_we);
                        if (mem_we) begin
                            written <= 1'b1;
                        end
                    end
                end
                CAS_FIRST: begin
                    dout_valid <= 1'b0;
                    if (ras_fall) begin
                        refresh_count <= refresh_count + CNT_W'(1);
                        state         <= CBR;
                    end else if (cas_rise) begin
                        state <= IDLE;
                    end
                end
                CBR: begin
                    dout_valid <= 1'b0;
                    if (ras && cas) begin
                        state <= IDLE;
                    end
                end
                WAIT_HI: begin
                    dout_valid <= 1'b0;
                    if (ras && cas) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_array_model.sv
// Directed bench for dram_array_model: read data is checked by a scoreboard
// monitor, counters and flags are checked inline after each sample.
module tb_dram_array_model;

    logic        clk_in;
    logic        rst;
    logic        ras;
    logic        cas;
    logic        w;
    logic [7:0]  ba;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [15:0] access_count;
    logic [15:0] refresh_count;
    logic        err_proto;

    int          checks = 0;
    int          errors = 0;
    int          exp_access = 0;
    int          exp_refresh = 0;
    logic [7:0]  exp_q[$];
    logic        prev_valid = 1'b0;

    dram_array_model dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .ras           (ras),
        .cas           (cas),
        .w             (w),
        .ba            (ba),
        .din           (din),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .access_count  (access_count),
        .refresh_count (refresh_count),
        .err_proto     (err_proto)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every new read burst (rising dout_valid) consumes one expected byte.
    always @(negedge clk_in) begin
        if (rst !== 1'b0) begin
            prev_valid = 1'b0;
        end else begin
            if (dout_valid === 1'b1 && prev_valid !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL read_data: unexpected dout_valid, dout=%02h, no read pending", dout);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (dout !== exp) begin
                        errors++;
                        $display("[TB] FAIL read_data: got %02h, expected %02h", dout, exp);
                    end
                end
            end
            prev_valid = dout_valid;
        end
    end

    task automatic applyStimulus(input logic r, input logic c, input logic wn,
                                 input logic [7:0] a, input logic [7:0] d);
        ras = r;
        cas = c;
        w   = wn;
        ba  = a;
        din = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic writeCycle(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, r, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, c, d);
        applyStimulus(1'b0, 1'b0, 1'b1, c, 8'h00);
        checkOutput("write_no_valid", int'(dout_valid), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, c, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        exp_access++;
    endtask

    task automatic readCycle(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, r, 8'h00);
        exp_q.push_back(d);
        applyStimulus(1'b0, 1'b0, 1'b1, c, 8'h00);
        checkOutput("read_latency_early", int'(dout_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, c, 8'h00);
        checkOutput("read_latency_valid", int'(dout_valid), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, c, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        exp_access++;
    endtask

    initial begin
        rst = 1'b1;
        ras = 1'b1;
        cas = 1'b1;
        w   = 1'b1;
        ba  = 8'h00;
        din = 8'h00;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        checkOutput("reset_dout", int'(dout), 0);
        checkOutput("reset_valid", int'(dout_valid), 0);
        checkOutput("reset_access", int'(access_count), 0);
        checkOutput("reset_refresh", int'(refresh_count), 0);
        checkOutput("reset_err", int'(err_proto), 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);

        $display("[TB] write then read at 1234h");
        writeCycle(8'h12, 8'h34, 8'hA5);
        checkOutput("write_access", int'(access_count), exp_access);
        readCycle(8'h12, 8'h34, 8'hA5);
        checkOutput("read_access", int'(access_count), exp_access);

        $display("[TB] page mode on row 40h");
        writeCycle(8'h40, 8'h00, 8'h11);
        writeCycle(8'h40, 8'h01, 8'h22);
        writeCycle(8'h40, 8'h02, 8'h33);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40, 8'h00);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] pcol;
            logic [7:0] pdat;
            pcol = 8'(i);
            pdat = 8'(8'h11 * (i + 1));
            exp_q.push_back(pdat);
            applyStimulus(1'b0, 1'b0, 1'b1, pcol, 8'h00);
            applyStimulus(1'b0, 1'b0, 1'b1, pcol, 8'h00);
            applyStimulus(1'b0, 1'b1, 1'b1, pcol, 8'h00);
            exp_access++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        checkOutput("page_access", int'(access_count), exp_access);
        checkOutput("page_refresh", int'(refresh_count), 0);

        $display("[TB] RAS-only refresh");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'h40, 8'h00);
            checkOutput("ror_no_valid", int'(dout_valid), 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        exp_refresh++;
        checkOutput("ror_refresh", int'(refresh_count), exp_refresh);
        checkOutput("ror_access", int'(access_count), exp_access);

        $display("[TB] CAS-before-RAS refresh with w low");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h02, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h02, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h02, 8'hFF);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        exp_refresh++;
        checkOutput("cbr_refresh", int'(refresh_count), exp_refresh);
        checkOutput("cbr_access", int'(access_count), exp_access);
        readCycle(8'h40, 8'h02, 8'h33);

        $display("[TB] simultaneous RAS/CAS fall");
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 8'h00);
        checkOutput("err_pulse", int'(err_proto), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 8'h00);
        checkOutput("err_one_cycle", int'(err_proto), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        checkOutput("err_access", int'(access_count), exp_access);
        checkOutput("err_refresh", int'(refresh_count), exp_refresh);

        $display("[TB] reset during column access");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h12, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h34, 8'h00);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h34, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        checkOutput("rst_mid_dout", int'(dout), 0);
        checkOutput("rst_mid_valid", int'(dout_valid), 0);
        checkOutput("rst_mid_access", int'(access_count), 0);
        checkOutput("rst_mid_refresh", int'(refresh_count), 0);
        rst = 1'b0;
        exp_access = 0;
        exp_refresh = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        readCycle(8'h12, 8'h34, 8'hA5);
        checkOutput("post_rst_access", int'(access_count), exp_access);

        @(negedge clk_in);
        #1;
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
